// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared state/grant encodings and watchdog sizing for the
//               two-master Wishbone arbiter.
// Revision    : 1.0
// ============================================================================
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ABORT   = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1 bit.
    function automatic int wd_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_select
// Description : Combinational tie-break returning a one-hot grant from the
//               request vector and the last-granted master.
// Revision    : 1.0
// ============================================================================
module wb_arb_select
    import wb_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = GNT_NONE;
        case (i_req)
            2'b01:   o_grant = GNT_M0;
            2'b10:   o_grant = GNT_M1;
            // i_last = 1 means master 1 held the bus most recently
            2'b11:   o_grant = (ROUND_ROBIN != 0 && !i_last) ? GNT_M1 : GNT_M0;
            default: o_grant = GNT_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_2
// Description : Two-master / one-slave Wishbone arbiter with per-CYC grant
//               locking and a stalled-strobe watchdog that aborts with ERR.
// Revision    : 1.0
// ============================================================================
module wb_arbiter_2
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int ROUND_ROBIN  = 0,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,

    output logic [1:0]              grant,
    output logic                    timeout_event
);

    localparam int              WD_W       = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] c_WD_LIMIT = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    arb_state_t      r_state;
    logic [1:0]      r_grant;
    logic            r_last;
    logic [WD_W-1:0] r_wd;

    logic [1:0]      w_req;
    logic [1:0]      w_sel_grant;
    logic            w_g_cyc;
    logic            w_g_stb;
    logic            w_stall;
    logic            w_wd_hit;
    logic            w_active;
    logic            w_abort;

    assign w_req = {wbm1_cyc_i, wbm0_cyc_i};

    wb_arb_select #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_select (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_sel_grant)
    );

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        w_g_cyc   = 1'b0;
        w_g_stb   = 1'b0;
        if (r_grant == GNT_M0) begin
            wbs_adr_o = wbm0_adr_i;
            wbs_dat_o = wbm0_dat_i;
            wbs_sel_o = wbm0_sel_i;
            wbs_we_o  = wbm0_we_i;
            w_g_cyc   = wbm0_cyc_i;
            w_g_stb   = wbm0_stb_i;
        end else if (r_grant == GNT_M1) begin
            wbs_adr_o = wbm1_adr_i;
            wbs_dat_o = wbm1_dat_i;
            wbs_sel_o = wbm1_sel_i;
            wbs_we_o  = wbm1_we_i;
            w_g_cyc   = wbm1_cyc_i;
            w_g_stb   = wbm1_stb_i;
        end
    end

    assign w_active = (r_state == GRANTED);
    assign w_abort  = (r_state == ABORT);
    // A slave response in the limit cycle clears w_stall, so it beats the abort
    assign w_stall  = w_g_stb & ~wbs_ack_i & ~wbs_err_i;
    assign w_wd_hit = (TIMEOUT != 0) && (r_wd == c_WD_LIMIT);

    assign wbs_cyc_o     = w_active & w_g_cyc;
    assign wbs_stb_o     = w_active & w_g_stb;
    assign grant         = r_grant;
    assign timeout_event = w_abort;

    assign wbm0_ack_o = w_active & r_grant[0] & wbs_ack_i;
    assign wbm1_ack_o = w_active & r_grant[1] & wbs_ack_i;
    assign wbm0_err_o = r_grant[0] & ((w_active & wbs_err_i) | w_abort);
    assign wbm1_err_o = r_grant[1] & ((w_active & wbs_err_i) | w_abort);
    assign wbm0_dat_o = r_grant[0] ? wbs_dat_i : '0;
    assign wbm1_dat_o = r_grant[1] ? wbs_dat_i : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= GNT_NONE;
            r_last  <= 1'b1;
            r_wd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wd <= '0;
                    if (|w_req) begin
                        r_grant <= w_sel_grant;
                        r_last  <= w_sel_grant[1];
                        r_state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!w_g_cyc) begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                        r_wd    <= '0;
                    end else if (w_stall && TIMEOUT != 0) begin
                        if (w_wd_hit) begin
                            r_state <= ABORT;
                            r_wd    <= '0;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end else begin
                        r_wd <= '0;
                    end
                end
                ABORT: begin
                    r_wd <= '0;
                    if (w_g_cyc) begin
                        r_state <= GRANTED;
                    end else begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                    r_wd    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter_2
// Description : Scoreboard bench for wb_arbiter_2 (round-robin, TIMEOUT=8)
//               with a fixed-priority, watchdog-off twin on shared stimulus.
// Revision    : 1.0
// ============================================================================
module tb_wb_arbiter_2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_stb [2];
    logic        m_cyc [2];

    logic [31:0] a_dat [2];
    logic        a_ack [2];
    logic        a_err [2];
    logic [31:0] b_dat [2];
    logic        b_ack [2];
    logic        b_err [2];

    logic [31:0] s_adr, s_wdat, s_rdat, b_adr, b_wdat;
    logic [3:0]  s_sel, b_sel;
    logic        s_we, s_stb, s_cyc, s_ack, s_err;
    logic        b_we, b_stb, b_cyc;
    logic [1:0]  a_grant, b_grant;
    logic        a_tev, b_tev;

    wb_arbiter_2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst(rst),
        .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(a_dat[0]), .wbm0_we_i(m_we[0]),
        .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]), .wbm0_cyc_i(m_cyc[0]),
        .wbm0_ack_o(a_ack[0]), .wbm0_err_o(a_err[0]),
        .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(a_dat[1]), .wbm1_we_i(m_we[1]),
        .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]), .wbm1_cyc_i(m_cyc[1]),
        .wbm1_ack_o(a_ack[1]), .wbm1_err_o(a_err[1]),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_dat_i(s_rdat), .wbs_we_o(s_we),
        .wbs_sel_o(s_sel), .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .grant(a_grant), .timeout_event(a_tev)
    );

    wb_arbiter_2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT(0)) u_fp (
        .clk(clk), .rst(rst),
        .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(b_dat[0]), .wbm0_we_i(m_we[0]),
        .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]), .wbm0_cyc_i(m_cyc[0]),
        .wbm0_ack_o(b_ack[0]), .wbm0_err_o(b_err[0]),
        .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(b_dat[1]), .wbm1_we_i(m_we[1]),
        .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]), .wbm1_cyc_i(m_cyc[1]),
        .wbm1_ack_o(b_ack[1]), .wbm1_err_o(b_err[1]),
        .wbs_adr_o(b_adr), .wbs_dat_o(b_wdat), .wbs_dat_i(s_rdat), .wbs_we_o(b_we),
        .wbs_sel_o(b_sel), .wbs_stb_o(b_stb), .wbs_cyc_o(b_cyc),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .grant(b_grant), .timeout_event(b_tev)
    );

    typedef struct {
        bit        we;
        bit [31:0] adr;
        bit [31:0] dat;
        bit [3:0]  sel;
        int        lat;
        bit        gap;
    } acc_t;

    typedef struct {
        int        m;
        bit        err;
        bit        chk;
        bit [31:0] dat;
    } exp_t;

    acc_t      plan [2][$];
    exp_t      sbq [$];
    bit [31:0] emem [128];
    bit [31:0] smem [128];
    int        lat_m [2];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        last_m;
    int        cyc_n = 0;
    int        s_cnt = 0;
    bit        b_tev_seen = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) if (!rst && b_tev === 1'b1) b_tev_seen = 1'b1;

    // Slave: acks after lat_m[owner] wait cycles; owner is address bit 8.
    always @(negedge clk) begin
        if (rst) begin
            s_ack  = 1'b0;
            s_cnt  = 0;
            s_rdat = $urandom;
        end else if (s_cyc === 1'b1 && s_stb === 1'b1) begin
            if (s_cnt >= lat_m[s_adr[8]]) begin
                s_ack = 1'b1;
                s_cnt = 0;
                if (s_we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) smem[s_adr[8:2]][8*b +: 8] = s_wdat[8*b +: 8];
                    s_rdat = $urandom;
                end else begin
                    s_rdat = smem[s_adr[8:2]];
                end
            end else begin
                s_ack  = 1'b0;
                s_cnt  = s_cnt + 1;
                s_rdat = $urandom;
            end
        end else begin
            s_ack  = 1'b0;
            s_cnt  = 0;
            s_rdat = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected completions for a burst, in issue order, against the model memory.
    task automatic push_plan(input int m);
        acc_t a;
        exp_t e;
        for (int i = 0; i < plan[m].size(); i++) begin
            a     = plan[m][i];
            e.m   = m;
            e.err = (a.lat >= 8);
            e.chk = 1'b0;
            e.dat = '0;
            if (!e.err) begin
                if (a.we) begin
                    for (int b = 0; b < 4; b++)
                        if (a.sel[b]) emem[a.adr[8:2]][8*b +: 8] = a.dat[8*b +: 8];
                end else begin
                    e.chk = 1'b1;
                    e.dat = emem[a.adr[8:2]];
                end
            end
            sbq.push_back(e);
        end
    endtask

    task automatic gen_plan(input int m);
        acc_t a;
        int   n;
        n = 1 + int'($urandom % 4);
        for (int i = 0; i < n; i++) begin
            a.we  = 1'($urandom % 2);
            a.adr = 32'(m << 8) | 32'(($urandom % 16) << 2);
            a.dat = $urandom;
            a.sel = 4'($urandom % 16);
            if (a.sel == 4'h0) a.sel = 4'hF;
            case ($urandom % 8)
                0:       a.lat = 20;
                1:       a.lat = 7;
                default: a.lat = int'($urandom % 4);
            endcase
            a.gap = ($urandom % 4 == 0);
            plan[m].push_back(a);
        end
    endtask

    // Master driver; must be entered just after a tick.
    task automatic do_burst(input int m);
        acc_t a;
        bit   seen;
        m_cyc[m] = 1'b1;
        while (plan[m].size() > 0) begin
            a        = plan[m].pop_front();
            m_we[m]  = a.we;
            m_adr[m] = a.adr;
            m_dat[m] = a.dat;
            m_sel[m] = a.sel;
            lat_m[m] = a.lat;
            m_stb[m] = 1'b1;
            seen     = 1'b0;
            for (int k = 0; k < 300; k++) begin
                samp();
                if (a_ack[m] === 1'b1 || a_err[m] === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            if (!seen) begin
                n_tests++;
                n_fail++;
                $display("FAIL burst_wait m%0d: got no ack/err, expected a response", m);
            end
            tick();
            if (a.gap) begin
                m_stb[m] = 1'b0;
                tick();
            end
        end
        m_stb[m] = 1'b0;
        m_cyc[m] = 1'b0;
        tick();
        samp();
        chk("dead_cycle_grant", 64'(a_grant), 64'd0);
    endtask

    task automatic round(input int pat);
        int w;
        if (pat == 2) begin
            w = 1 - last_m;
            gen_plan(0);
            gen_plan(1);
            push_plan(w);
            push_plan(1 - w);
            last_m = 1 - w;
            fork
                do_burst(0);
                do_burst(1);
            join
        end else begin
            gen_plan(pat);
            push_plan(pat);
            last_m = pat;
            do_burst(pat);
        end
        tick();
    endtask

    // Monitor: every master response is matched against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0) begin
                for (int m = 0; m < 2; m++) begin
                    if (a_ack[m] === 1'b1 || a_err[m] === 1'b1) begin
                        n_tests++;
                        if (sbq.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_resp m%0d: got ack=%0b err=%0b, expected none",
                                     m, a_ack[m], a_err[m]);
                        end else begin
                            e  = sbq.pop_front();
                            ok = (e.m == m) && (a_err[m] === e.err) && (a_ack[m] === !e.err) &&
                                 (a_tev === e.err) && (!e.chk || a_dat[m] === e.dat);
                            if (!ok) begin
                                n_fail++;
                                $display("FAIL resp: got m%0d ack=%0b err=%0b tev=%0b dat=%h, expected m%0d err=%0b dat=%h",
                                         m, a_ack[m], a_err[m], a_tev, a_dat[m], e.m, e.err, e.dat);
                            end
                        end
                    end
                end
                if (a_tev === 1'b1 && a_err[0] !== 1'b1 && a_err[1] !== 1'b1) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tev_without_err: got timeout_event=1, expected an err_o");
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int  t0;
        bit  seen;
        exp_t e;
        logic [1:0] exp_g;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0;
            m_we[m]  = 1'b0; m_stb[m] = 1'b0; m_cyc[m] = 1'b0;
            lat_m[m] = 0;
        end
        s_err  = 1'b0;
        last_m = 1;
        rst    = 1'b1;
        repeat (3) tick();
        samp();
        chk("rst_grant", 64'(a_grant), 64'd0);
        chk("rst_cyc",   64'(s_cyc),   64'd0);
        chk("rst_stb",   64'(s_stb),   64'd0);
        chk("rst_tev",   64'(a_tev),   64'd0);
        chk("rst_err0",  64'(a_err[0]), 64'd0);
        tick();
        rst = 1'b0;

        // Simultaneous CYC, three times: alternate vs. fixed priority
        for (int r = 0; r < 3; r++) begin
            tick();
            m_cyc[0] = 1'b1;
            m_cyc[1] = 1'b1;
            tick();
            samp();
            exp_g  = (last_m == 0) ? 2'b10 : 2'b01;
            last_m = (last_m == 0) ? 1 : 0;
            chk("tie_rr_grant", 64'(a_grant), 64'(exp_g));
            chk("tie_fp_grant", 64'(b_grant), 64'd1);
            tick();
            m_cyc[0] = 1'b0;
            m_cyc[1] = 1'b0;
            tick();
            samp();
            chk("tie_dead", 64'(a_grant), 64'd0);
        end

        // Single master-0 write, then read it back
        tick();
        plan[0].push_back('{we: 1'b1, adr: 32'h10, dat: 32'hA5A5A5A5, sel: 4'hF, lat: 1, gap: 1'b0});
        push_plan(0);
        last_m = 0;
        fork
            do_burst(0);
            begin
                samp();
                chk("t1_idle_grant", 64'(a_grant), 64'd0);
                tick();
                samp();
                chk("t1_grant", 64'(a_grant), 64'd1);
                chk("t1_adr",   64'(s_adr),   64'h10);
                chk("t1_dat",   64'(s_wdat),  64'hA5A5A5A5);
                chk("t1_sel",   64'(s_sel),   64'hF);
                chk("t1_we",    64'(s_we),    64'd1);
                chk("t1_m1_ack", 64'(a_ack[1]), 64'd0);
            end
        join
        tick();
        plan[0].push_back('{we: 1'b0, adr: 32'h10, dat: 32'h0, sel: 4'hF, lat: 0, gap: 1'b0});
        push_plan(0);
        do_burst(0);

        // Master 1 holds the bus for four accesses while master 0 waits
        tick();
        for (int i = 0; i < 4; i++)
            plan[1].push_back('{we: 1'b1, adr: 32'h100 + 32'(4*i), dat: $urandom, sel: 4'hF, lat: 1, gap: 1'b0});
        plan[0].push_back('{we: 1'b0, adr: 32'h10, dat: 32'h0, sel: 4'hF, lat: 0, gap: 1'b0});
        push_plan(1);
        push_plan(0);
        last_m = 0;
        fork
            do_burst(1);
            begin
                tick();
                tick();
                do_burst(0);
            end
        join

        // Watchdog: stalled read aborts on stalled cycle 9, then an ack on cycle 8 wins
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h20; m_sel[0] = 4'hF;
        lat_m[0] = 20;
        e = '{m: 0, err: 1'b1, chk: 1'b0, dat: 32'h0};
        sbq.push_back(e);
        tick();
        samp();
        t0 = cyc_n;
        chk("to_grant_start", 64'(a_grant), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (a_err[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
            samp();
        end
        chk("to_err_seen", 64'(seen),        64'd1);
        chk("to_cycles",   64'(cyc_n - t0),  64'd8);
        chk("to_stb",      64'(s_stb),       64'd0);
        chk("to_cyc",      64'(s_cyc),       64'd0);
        chk("to_tev",      64'(a_tev),       64'd1);
        chk("to_grant",    64'(a_grant),     64'd1);
        tick();
        m_adr[0] = 32'h24;
        lat_m[0] = 7;
        e = '{m: 0, err: 1'b0, chk: 1'b1, dat: emem[32'h24 >> 2]};
        sbq.push_back(e);
        samp();
        t0 = cyc_n;
        chk("to_hold_grant", 64'(a_grant), 64'd1);
        chk("to_tev_pulse",  64'(a_tev),   64'd0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (a_ack[0] === 1'b1 || a_err[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
            samp();
        end
        chk("edge_ack_cycles", 64'(cyc_n - t0), 64'd7);
        chk("edge_ack_noerr",  64'(a_err[0]),   64'd0);
        tick();
        m_stb[0] = 1'b0;
        m_cyc[0] = 1'b0;
        repeat (2) tick();

        // Reset while master 1 is stalled mid-access
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h104; m_sel[1] = 4'hF;
        lat_m[1] = 20;
        repeat (3) tick();
        samp();
        chk("rst_mid_pre_grant", 64'(a_grant), 64'd2);
        tick();
        rst = 1'b1;
        tick();
        samp();
        chk("rst_mid_cyc",   64'(s_cyc),    64'd0);
        chk("rst_mid_stb",   64'(s_stb),    64'd0);
        chk("rst_mid_grant", 64'(a_grant),  64'd0);
        chk("rst_mid_err",   64'(a_err[1]), 64'd0);
        tick();
        rst      = 1'b0;
        lat_m[1] = 0;
        last_m   = 1;
        e = '{m: 1, err: 1'b0, chk: 1'b1, dat: emem[32'h104 >> 2]};
        sbq.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            samp();
            if (a_ack[1] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_mid_rearb", 64'(seen), 64'd1);
        tick();
        m_stb[1] = 1'b0;
        m_cyc[1] = 1'b0;
        tick();
        tick();

        // Randomized traffic: master 0 only, master 1 only, or both at once
        for (int r = 0; r < 40; r++)
            round(int'($urandom % 3));

        repeat (4) tick();
        chk("sb_empty",      64'(sbq.size()), 64'd0);
        chk("fp_no_timeout", 64'(b_tev_seen), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_2.md
Name: wb_arbiter_2

Overview:
- Two-master, one-slave Wishbone arbiter with cycle locking and a stall watchdog.
- Lets the I2C slave Wishbone bridge (master 0) and a second on-chip master (master 1, e.g. a CPU or DMA) share one Wishbone slave bus (register file or RAM).
- A grant is held for the whole CYC period of the granted master.
- A hung slave cannot lock the bus forever: the watchdog terminates the stalled access with an error.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64).
- ADDR_WIDTH, 32, address bus width in bits.
- SELECT_WIDTH, DATA_WIDTH/8, byte select width.
- ROUND_ROBIN, 0: 0 = fixed priority, master 0 wins; 1 = on a simultaneous request, the master not granted last wins.
- TIMEOUT, 1024: stalled-strobe cycles before an abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wbm0_adr_i  in  ADDR_WIDTH  master 0 address.
- wbm0_dat_i  in  DATA_WIDTH  master 0 write data.
- wbm0_dat_o  out  DATA_WIDTH  master 0 read data.
- wbm0_we_i, wbm0_stb_i, wbm0_cyc_i  in  1  master 0 write enable, strobe, cycle.
- wbm0_sel_i  in  SELECT_WIDTH  master 0 byte select.
- wbm0_ack_o, wbm0_err_o  out  1  master 0 acknowledge, error.
- wbm1_*  (same set as wbm0_*)  master 1.
- wbs_adr_o  out  ADDR_WIDTH  slave address.
- wbs_dat_o  out  DATA_WIDTH  slave write data.
- wbs_dat_i  in  DATA_WIDTH  slave read data.
- wbs_we_o, wbs_stb_o, wbs_cyc_o  out  1  slave write enable, strobe, cycle.
- wbs_sel_o  out  SELECT_WIDTH  slave byte select.
- wbs_ack_i, wbs_err_i  in  1  slave acknowledge, error.
- grant  out  2  one-hot current grant (bit n = master n); 0 = none.
- timeout_event  out  1  one-cycle pulse on every watchdog abort.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, grant 0, watchdog count 0, last-grant pointer = master 1 (so master 0 wins the first round-robin tie). All wbs_* control outputs, all ack/err, and timeout_event are 0 the cycle after reset is sampled.
- Outputs are combinational from registered state and grant.
- wbs_adr/dat/we/sel_o follow the granted master; they are 0 when there is no grant.
- wbs_cyc_o = granted cyc_i. wbs_stb_o = granted stb_i. Both are forced 0 in ABORT and in IDLE.
- Slave ack/err/dat route only to the granted master. The non-granted master sees ack_o = err_o = 0 and dat_o = 0.
- IDLE:
  - Sample wbm0_cyc_i and wbm1_cyc_i.
  - One requester: grant it.
  - Two requesters: fixed priority (ROUND_ROBIN=0) or alternating (ROUND_ROBIN=1).
  - Next state GRANTED; grant is registered, giving 1 cycle of arbitration latency.
  - Update the last-grant pointer.
- GRANTED:
  - Hold the grant while the granted cyc_i = 1. The other master's cyc_i is ignored.
  - Granted cyc_i = 0 → IDLE. One dead cycle always separates consecutive grants.
- Watchdog (GRANTED only):
  - Counter increments on each cycle with granted stb_i = 1 and wbs_ack_i = wbs_err_i = 0.
  - It clears on ack, err, stb low, or a grant change.
  - count reaching TIMEOUT-1 while still stalled → ABORT on the next edge.
  - ack/err in the same cycle as the limit wins: no abort.
  - TIMEOUT = 0: never abort.
- ABORT (exactly 1 cycle):
  - Granted err_o = 1, ack_o = 0, timeout_event = 1.
  - wbs_stb_o = wbs_cyc_o = 0, terminating the cycle at the slave.
  - Any wbs_ack_i/err_i in this cycle is discarded.
  - Next state: GRANTED if granted cyc_i = 1, else IDLE. Counter is 0.
- A master dropping cyc_i mid-access is legal and returns the arbiter to IDLE; the counter clears.
- Reset mid-transfer: the grant drops, and slave cyc/stb go low the following cycle with no error pulse.
- Counter width is clog2(TIMEOUT+1), minimum 1 bit. No wrap is possible because the count saturates at the abort point.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding: IDLE = 2'd0, GRANTED = 2'd1, ABORT = 2'd2;
  - grant encodings: GNT_NONE, GNT_M0, GNT_M1;
  - the watchdog-width function.
- One natural sub-module: wb_arb_select. It is combinational tie-break logic taking the request vector, ROUND_ROBIN and the last-grant pointer, and returning a one-hot grant.
- The FSM, the watchdog counter and the muxing stay in wb_arbiter_2.

Test Plan:
- Only master 0 issues write adr 0x10, data 0xA5A5A5A5, sel 0xF, slave acks after 2 cycles → grant = 01 one cycle after cyc; slave sees identical adr/dat/sel; wbm0_ack_o pulses once; wbm1_ack_o stays 0; grant returns to 00 one cycle after cyc drops.
- Both cycs rise in the same cycle, ROUND_ROBIN = 0, repeated 3 times → master 0 wins all 3 grants. With ROUND_ROBIN = 1 the grants are m0, m1, m0, with one dead cycle between each.
- Master 1 granted and holding cyc for 4 accesses while master 0 requests → master 0 is never acked. Grant moves to master 0 only after a dead cycle following master 1's cyc drop.
- TIMEOUT = 8, slave never acks master 0's read → ABORT on cycle 9 of stb: wbm0_err_o = 1 and timeout_event = 1 for one cycle, wbs_stb_o = 0 in that cycle, grant retained while cyc is held.
- TIMEOUT = 8, slave acks on exactly the 8th stalled cycle → normal ack, no err, no timeout_event.
- rst asserted while master 1 is mid-access with slave stalled → next cycle wbs_cyc_o = wbs_stb_o = 0, grant = 00, no err pulse; after rst is released the master re-arbitrates normally.
